// File: rtl/uart_rx_cozucu.sv
// 8N1 UART receive front end: 2-flop synchronizer, mid-bit sampling FSM and FWFT byte FIFO.
// Optional even-parity bit and parite_hata_o pulse when UART_PARITE_EN is defined.
module uart_rx_cozucu #(
  parameter int FIFO_DERINLIK   = 16,
  parameter int SAYAC_GENISLIGI = 16
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic [SAYAC_GENISLIGI-1:0] baud_clk_i,
  input  logic                       rx_en_i,
  input  logic                       rx_oku_en,
  input  logic                       rx_veri_i,
  output logic [7:0]                 rx_veri_o,
  output logic                       rx_fifo_bos,
  output logic                       rx_fifo_dolu,
  output logic                       cerceve_hata_o,
  output logic                       tasma_o,
  output logic                       parite_hata_o
);

  localparam int AW = $clog2(FIFO_DERINLIK);
  localparam logic [AW:0] DERINLIK_C = (AW+1)'(FIFO_DERINLIK);
  localparam logic [SAYAC_GENISLIGI-1:0] BIR_C = SAYAC_GENISLIGI'(1);

  typedef enum logic [2:0] {
    BOSTA,
    BASLA,
    VERI,
`ifdef UART_PARITE_EN
    PARITE,
`endif
    DUR
  } durum_t;

  durum_t                     durum_q, durum_d;
  logic                       senk1_q, senk2_q, onceki_q;
  logic [SAYAC_GENISLIGI-1:0] sayac_q, sayac_d;
  logic [SAYAC_GENISLIGI-1:0] bolen_q, bolen_d;
  logic [2:0]                 bit_idx_q, bit_idx_d;
  logic [7:0]                 veri_q, veri_d;
  logic                       cerceve_q, cerceve_d;
  logic                       tasma_q, tasma_d;
  logic                       push, sayac_sifir, devre_disi;
`ifdef UART_PARITE_EN
  logic                       par_hata_q, par_hata_d;
  logic                       parite_q, parite_d;
`endif

  logic [7:0]    mem [FIFO_DERINLIK];
  logic [AW-1:0] yaz_ptr_q, oku_ptr_q;
  logic [AW:0]   adet_q;
  logic          pop, yaz;

  assign sayac_sifir = (sayac_q == '0);
  assign devre_disi  = !rx_en_i || (baud_clk_i < SAYAC_GENISLIGI'(4));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      senk1_q   <= 1'b1;
      senk2_q   <= 1'b1;
      onceki_q  <= 1'b1;
      durum_q   <= BOSTA;
      sayac_q   <= '0;
      bolen_q   <= '0;
      bit_idx_q <= '0;
      veri_q    <= '0;
      cerceve_q <= 1'b0;
      tasma_q   <= 1'b0;
`ifdef UART_PARITE_EN
      par_hata_q <= 1'b0;
      parite_q   <= 1'b0;
`endif
    end else begin
      senk1_q   <= rx_veri_i;
      senk2_q   <= senk1_q;
      onceki_q  <= senk2_q;
      durum_q   <= durum_d;
      sayac_q   <= sayac_d;
      bolen_q   <= bolen_d;
      bit_idx_q <= bit_idx_d;
      veri_q    <= veri_d;
      cerceve_q <= cerceve_d;
      tasma_q   <= tasma_d;
`ifdef UART_PARITE_EN
      par_hata_q <= par_hata_d;
      parite_q   <= parite_d;
`endif
    end
  end

  // Reloads use bolen-1 because the zero cycle itself counts, giving exactly bolen cycles per bit.
  always_comb begin
    durum_d   = durum_q;
    sayac_d   = sayac_q;
    bolen_d   = bolen_q;
    bit_idx_d = bit_idx_q;
    veri_d    = veri_q;
    cerceve_d = 1'b0;
    push      = 1'b0;
`ifdef UART_PARITE_EN
    par_hata_d = par_hata_q;
    parite_d   = 1'b0;
`endif
    case (durum_q)
      BOSTA: begin
        if (onceki_q && !senk2_q) begin
          bolen_d = baud_clk_i;
          sayac_d = baud_clk_i >> 1;
          durum_d = BASLA;
        end
      end
      BASLA: begin
        if (!sayac_sifir) begin
          sayac_d = sayac_q - BIR_C;
        end else if (senk2_q) begin
          durum_d = BOSTA;
        end else begin
          sayac_d   = bolen_q - BIR_C;
          bit_idx_d = '0;
          durum_d   = VERI;
        end
      end
      VERI: begin
        if (!sayac_sifir) begin
          sayac_d = sayac_q - BIR_C;
        end else begin
          veri_d[bit_idx_q] = senk2_q;
          sayac_d           = bolen_q - BIR_C;
          bit_idx_d         = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_PARITE_EN
            durum_d = PARITE;
`else
            durum_d = DUR;
`endif
          end
        end
      end
`ifdef UART_PARITE_EN
      PARITE: begin
        if (!sayac_sifir) begin
          sayac_d = sayac_q - BIR_C;
        end else begin
          par_hata_d = (^veri_q) ^ senk2_q;
          sayac_d    = bolen_q - BIR_C;
          durum_d    = DUR;
        end
      end
`endif
      DUR: begin
        if (!sayac_sifir) begin
          sayac_d = sayac_q - BIR_C;
        end else begin
          durum_d   = BOSTA;
          cerceve_d = !senk2_q;
`ifdef UART_PARITE_EN
          parite_d = par_hata_q;
          push     = senk2_q && !par_hata_q;
`else
          push     = senk2_q;
`endif
        end
      end
      default: durum_d = BOSTA;
    endcase
    if (devre_disi) begin
      durum_d   = BOSTA;
      push      = 1'b0;
      cerceve_d = 1'b0;
`ifdef UART_PARITE_EN
      parite_d = 1'b0;
`endif
    end
  end

  // A pop on a full FIFO frees the slot the simultaneous push needs.
  assign rx_fifo_bos  = (adet_q == '0);
  assign rx_fifo_dolu = (adet_q == DERINLIK_C);
  assign pop          = rx_oku_en && !rx_fifo_bos;
  assign yaz          = push && (!rx_fifo_dolu || pop);
  assign tasma_d      = push && rx_fifo_dolu && !pop;

  always_ff @(posedge clk_i) begin
    if (yaz) begin
      mem[yaz_ptr_q] <= veri_q;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      yaz_ptr_q <= '0;
      oku_ptr_q <= '0;
      adet_q    <= '0;
    end else begin
      if (yaz) yaz_ptr_q <= yaz_ptr_q + AW'(1);
      if (pop) oku_ptr_q <= oku_ptr_q + AW'(1);
      case ({yaz, pop})
        2'b10:   adet_q <= adet_q + (AW+1)'(1);
        2'b01:   adet_q <= adet_q - (AW+1)'(1);
        default: adet_q <= adet_q;
      endcase
    end
  end

  assign rx_veri_o      = rx_fifo_bos ? 8'h00 : mem[oku_ptr_q];
  assign cerceve_hata_o = cerceve_q;
  assign tasma_o        = tasma_q;
`ifdef UART_PARITE_EN
  assign parite_hata_o  = parite_q;
`else
  assign parite_hata_o  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_cozucu.sv
// Directed + randomized bench for uart_rx_cozucu (depth 4, divisor 16) with a queue-based FIFO model.
module tb_uart_rx_cozucu;
  localparam int DIV   = 16;
  localparam int DEPTH = 4;
`ifdef UART_PARITE_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int LAT_NOM = (NBITS - 1) * DIV + DIV / 2;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] baudClk;
  logic        rxEn, rxOkuEn, rxLine;
  logic [7:0]  rxVeri;
  logic        fifoBos, fifoDolu, cerceveHata, tasma, pariteHata;

  int checks = 0, errors = 0;
  int tasmaCnt = 0, cerceveCnt = 0, pariteCnt = 0;
  int lat = 0;
  logic [7:0] model[$];

  uart_rx_cozucu #(.FIFO_DERINLIK(DEPTH), .SAYAC_GENISLIGI(16)) dut (
    .clk_i(clk), .rstn_i(rstn), .baud_clk_i(baudClk), .rx_en_i(rxEn),
    .rx_oku_en(rxOkuEn), .rx_veri_i(rxLine), .rx_veri_o(rxVeri),
    .rx_fifo_bos(fifoBos), .rx_fifo_dolu(fifoDolu), .cerceve_hata_o(cerceveHata),
    .tasma_o(tasma), .parite_hata_o(pariteHata)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tasma === 1'b1)       tasmaCnt   <= tasmaCnt + 1;
    if (cerceveHata === 1'b1) cerceveCnt <= cerceveCnt + 1;
    if (pariteHata === 1'b1)  pariteCnt  <= pariteCnt + 1;
  end

  function automatic logic evenPar(input logic [7:0] d);
    return ^d;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic parBit, input logic stopBit);
    rxLine = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxLine = d[i];
      repeat (DIV) @(negedge clk);
    end
`ifdef UART_PARITE_EN
    rxLine = parBit;
    repeat (DIV) @(negedge clk);
`endif
    rxLine = stopBit;
    repeat (DIV) @(negedge clk);
    rxLine = 1'b1;
  endtask

  task automatic idle(input int n);
    rxLine = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic sendGood(input logic [7:0] d);
    applyStimulus(d, evenPar(d), 1'b1);
    idle(4);
  endtask

  task automatic popCheck(input string tag);
    logic [7:0] exp;
    exp = model.pop_front();
    checkOutput(tag, rxVeri, exp);
    rxOkuEn = 1'b1;
    @(negedge clk);
    rxOkuEn = 1'b0;
  endtask

  task automatic sendModel(input logic [7:0] d, inout int expTasma);
    sendGood(d);
    if (model.size() < DEPTH) model.push_back(d);
    else expTasma++;
  endtask

  initial begin
    int t0, c0, p0, expTasma;
    logic [7:0] d, b;
    rstn = 1'b0; baudClk = 16'(DIV); rxEn = 1'b1; rxOkuEn = 1'b0; rxLine = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_bos", fifoBos, 1);
    checkOutput("reset_dolu", fifoDolu, 0);
    checkOutput("reset_veri", rxVeri, 0);
    checkOutput("reset_tasma", tasma, 0);
    checkOutput("reset_cerceve", cerceveHata, 0);
    rstn = 1'b1;
    idle(5);

    // single byte with latency measurement
    d = 8'hA5;
    fork
      applyStimulus(d, evenPar(d), 1'b1);
      begin
        lat = 0;
        while (fifoBos === 1'b1 && lat < 400) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    idle(4);
    checkOutput("single_latency", (lat >= LAT_NOM - 2 && lat <= LAT_NOM + 10) ? 1 : 0, 1);
    model.push_back(d);
    checkOutput("single_bos", fifoBos, 0);
    popCheck("single_data");
    checkOutput("single_bos_after_pop", fifoBos, 1);

    // false start glitch, then a good byte
    c0 = cerceveCnt; t0 = tasmaCnt;
    rxLine = 1'b0;
    repeat (5) @(negedge clk);
    idle(3 * DIV);
    checkOutput("glitch_bos", fifoBos, 1);
    checkOutput("glitch_cerceve", cerceveCnt - c0, 0);
    checkOutput("glitch_tasma", tasmaCnt - t0, 0);
    d = 8'h3C;
    sendGood(d);
    model.push_back(d);
    popCheck("after_glitch_data");

    // overflow
    t0 = tasmaCnt; expTasma = 0;
    for (int i = 1; i <= 5; i++) begin
      sendModel(8'(i), expTasma);
      if (i == 4) checkOutput("ovf_dolu_after4", fifoDolu, 1);
    end
    checkOutput("ovf_tasma", tasmaCnt - t0, expTasma);
    while (model.size() > 0) popCheck("ovf_pop");
    checkOutput("ovf_bos", fifoBos, 1);

    // frame error followed by a good frame
    c0 = cerceveCnt;
    d = 8'h55;
    applyStimulus(d, evenPar(d), 1'b0);
    idle(2 * DIV);
    checkOutput("frame_err_pulse", cerceveCnt - c0, 1);
    checkOutput("frame_err_bos", fifoBos, 1);
    d = 8'hFF;
    sendGood(d);
    model.push_back(d);
    popCheck("after_frame_err_data");

    // full FIFO with pop on the stop-sample edge
    expTasma = 0;
    for (int i = 0; i < DEPTH; i++) sendModel(8'($urandom), expTasma);
    checkOutput("conc_dolu_before", fifoDolu, 1);
    t0 = tasmaCnt;
    d = 8'h77;
    fork
      applyStimulus(d, evenPar(d), 1'b1);
      begin
        repeat (lat - 1) @(negedge clk);
        b = model.pop_front();
        checkOutput("conc_popped_head", rxVeri, b);
        rxOkuEn = 1'b1;
        @(negedge clk);
        rxOkuEn = 1'b0;
      end
    join
    model.push_back(d);
    idle(4);
    checkOutput("conc_tasma", tasmaCnt - t0, 0);
    checkOutput("conc_dolu_after", fifoDolu, 1);
    while (model.size() > 0) popCheck("conc_drain");

    // randomized traffic against the queue model
    t0 = tasmaCnt; expTasma = 0;
    for (int i = 0; i < 10; i++) begin
      sendModel(8'($urandom), expTasma);
      if ($urandom_range(0, 1) == 1 && model.size() > 0) popCheck("rand_pop");
      checkOutput("rand_bos", fifoBos, (model.size() == 0) ? 1 : 0);
      checkOutput("rand_dolu", fifoDolu, (model.size() == DEPTH) ? 1 : 0);
    end
    checkOutput("rand_tasma", tasmaCnt - t0, expTasma);
    while (model.size() > 0) popCheck("rand_drain");

    // receiver disabled mid-frame
    c0 = cerceveCnt;
    fork
      applyStimulus(8'h5A, 1'b0, 1'b1);
      begin
        repeat (4 * DIV) @(negedge clk);
        rxEn = 1'b0;
      end
    join
    idle(2 * DIV);
    rxEn = 1'b1;
    idle(DIV);
    checkOutput("disable_bos", fifoBos, 1);
    checkOutput("disable_cerceve", cerceveCnt - c0, 0);

    // asynchronous reset mid-frame
    sendGood(8'h81);
    checkOutput("prereset_bos", fifoBos, 0);
    fork
      applyStimulus(8'hC3, 1'b0, 1'b1);
      begin
        repeat (3 * DIV) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        checkOutput("async_rst_bos", fifoBos, 1);
        checkOutput("async_rst_dolu", fifoDolu, 0);
        checkOutput("async_rst_veri", rxVeri, 0);
      end
    join
    idle(DIV);
    rstn = 1'b1;
    model.delete();
    idle(2 * DIV);
    checkOutput("post_reset_bos", fifoBos, 1);

`ifdef UART_PARITE_EN
    p0 = pariteCnt;
    applyStimulus(8'h07, 1'b0, 1'b1);
    idle(4);
    checkOutput("parity_err_pulse", pariteCnt - p0, 1);
    checkOutput("parity_err_bos", fifoBos, 1);
    d = 8'h07;
    sendGood(d);
    model.push_back(d);
    popCheck("parity_good_data");
`else
    p0 = 0;
    checkOutput("parity_never_pulses", pariteCnt - p0, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
